sfp_tx_framer: RTL and testbench

- Transmit-side link scheduler for the SFP 8b10b video path; sits between the TX line buffer FIFO (32-bit words) and the transceiver TX data/charisk inputs.
- Sequences each output word as idle filler, frame-sync K-pair, line-start K-pair, gapless payload or line-end K-pair, so the receive decoder can recover vsync, line boundaries and payload.
- Arbitrates pending frame-sync and line requests and enforces the guard and gap intervals the receiver needs.

---
 rtl/sfp_tx_framer.sv | 200 ++++++++++++++++++++
 tb/tb_sfp_tx_framer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_tx_framer.sv
// TX link scheduler for the SFP 8b10b video path: interleaves idle filler,
// frame-sync and line framing K-pairs with gapless line payload from the line FIFO.
module sfp_tx_framer #(
    parameter logic [31:0] VS_POSE_DATA1 = 32'h55a101bc,
    parameter logic [31:0] VS_POSE_DATA2 = 32'h55a102bc,
    parameter logic [31:0] DATA_START1   = 32'h55a105bc,
    parameter logic [31:0] DATA_START2   = 32'h55a106bc,
    parameter logic [31:0] DATA_END1     = 32'h55a107bc,
    parameter logic [31:0] DATA_END2     = 32'h55a108bc,
    parameter logic [31:0] UNUSE_DATA    = 32'h55a109bc,
    parameter int unsigned LINE_WORDS    = 960,
    parameter int unsigned VS_GUARD      = 128,
    parameter int unsigned LINE_GAP      = 16
) (
    input  logic        tx_clk,
    input  logic        tx_rst_n,
    input  logic        vs_in,
    input  logic        line_req,
    input  logic [31:0] payload_data,
    input  logic        payload_empty,
    output logic        payload_rd_en,
    output logic [31:0] tx_data,
    output logic [3:0]  tx_charisk,
    output logic        busy,
    output logic        line_drop,
    output logic        underrun
);

    localparam int unsigned      CNT_W      = 16;
    localparam logic [CNT_W-1:0] WORD_LAST  = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] WORD_TOTAL = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(VS_GUARD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(LINE_GAP - 1);
    localparam logic [3:0]       K_CTRL     = 4'b0001;
    localparam logic [3:0]       K_DATA     = 4'b0000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_VS1,
        S_VS2,
        S_VS_WAIT,
        S_ST1,
        S_ST2,
        S_PAY,
        S_END1,
        S_END2,
        S_GAP
    } state_t;

    state_t            state;
    state_t            state_next;
    state_t            arb_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  rd_cnt_next;
    logic              rd_en_next;
    logic              vs_pend;
    logic              line_pend;
    logic              vs_clr;
    logic              line_clr;
    logic [31:0]       data_next;
    logic [3:0]        charisk_next;

    // State register
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, interval counters and the word to launch next cycle
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        arb_state    = S_IDLE;
        data_next    = UNUSE_DATA;
        charisk_next = K_CTRL;
        rd_cnt_next  = rd_cnt;
        rd_en_next   = 1'b0;
        vs_clr       = 1'b0;
        line_clr     = 1'b0;

        // Frame sync wins over a pending line
        if (vs_pend) begin
            arb_state = S_VS1;
        end else if (line_pend) begin
            arb_state = S_ST1;
        end

        // Guard and gap expiry arbitrate directly so no extra idle word is spent
        case (state)
            S_IDLE: begin
                state_next = arb_state;
            end
            S_VS1: begin
                state_next = S_VS2;
            end
            S_VS2: begin
                state_next = S_VS_WAIT;
                cnt_next   = '0;
            end
            S_VS_WAIT: begin
                if (cnt == GUARD_LAST) begin
                    state_next = arb_state;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_ST1: begin
                state_next = S_ST2;
            end
            S_ST2: begin
                state_next = S_PAY;
                cnt_next   = '0;
            end
            S_PAY: begin
                if (cnt == WORD_LAST) begin
                    state_next = S_END1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_END1: begin
                state_next = S_END2;
            end
            S_END2: begin
                state_next = S_GAP;
                cnt_next   = '0;
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_next = arb_state;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase

        case (state_next)
            S_VS1:   data_next = VS_POSE_DATA1;
            S_VS2:   data_next = VS_POSE_DATA2;
            S_ST1:   data_next = DATA_START1;
            S_ST2:   data_next = DATA_START2;
            S_END1:  data_next = DATA_END1;
            S_END2:  data_next = DATA_END2;
            S_PAY: begin
                data_next    = payload_data;
                charisk_next = K_DATA;
            end
            default: data_next = UNUSE_DATA;
        endcase

        vs_clr   = (state_next == S_VS1);
        line_clr = (state_next == S_ST1);

        // Reads start with START1 and run two words ahead of the payload on tx_data
        if (state_next == S_ST1) begin
            rd_en_next  = 1'b1;
            rd_cnt_next = CNT_W'(1);
        end else if (payload_rd_en && (rd_cnt != WORD_TOTAL)) begin
            rd_en_next  = 1'b1;
            rd_cnt_next = rd_cnt + CNT_W'(1);
        end
    end

    // Registered outputs, counters and request latches
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            cnt           <= '0;
            rd_cnt        <= '0;
            vs_pend       <= 1'b0;
            line_pend     <= 1'b0;
            tx_data       <= UNUSE_DATA;
            tx_charisk    <= K_CTRL;
            payload_rd_en <= 1'b0;
            busy          <= 1'b0;
            line_drop     <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            cnt           <= cnt_next;
            rd_cnt        <= rd_cnt_next;
            vs_pend       <= vs_in | (vs_pend & ~vs_clr);
            line_pend     <= line_req | (line_pend & ~line_clr);
            tx_data       <= data_next;
            tx_charisk    <= charisk_next;
            payload_rd_en <= rd_en_next;
            busy          <= (state_next != S_IDLE);
            line_drop     <= line_req & line_pend & ~line_clr;
            underrun      <= payload_rd_en & payload_empty;
        end
    end

endmodule

// File: tb/tb_sfp_tx_framer.sv
// Scoreboard bench for sfp_tx_framer: stimulus queues per-cycle expected words
// and pulse counts; a negedge monitor pops and compares them against the DUT.
module tb_sfp_tx_framer;

    localparam int LW    = 4;
    localparam int GUARD = 128;
    localparam int GAP   = 16;

    localparam logic [31:0] VS1_W   = 32'h55a101bc;
    localparam logic [31:0] VS2_W   = 32'h55a102bc;
    localparam logic [31:0] ST1_W   = 32'h55a105bc;
    localparam logic [31:0] ST2_W   = 32'h55a106bc;
    localparam logic [31:0] END1_W  = 32'h55a107bc;
    localparam logic [31:0] END2_W  = 32'h55a108bc;
    localparam logic [31:0] IDLE_W  = 32'h55a109bc;

    localparam int KIND_WORD = 0;
    localparam int KIND_DROP = 1;
    localparam int KIND_UND  = 2;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] data;
        logic [3:0]  k;
        logic        rd;
        logic        bz;
    } exp_t;

    logic        tx_clk;
    logic        tx_rst_n;
    logic        vs_in;
    logic        line_req;
    logic [31:0] payload_data;
    logic        payload_empty;
    logic        payload_rd_en;
    logic [31:0] tx_data;
    logic [3:0]  tx_charisk;
    logic        busy;
    logic        line_drop;
    logic        underrun;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          drop_seen = 0;
    int          und_seen = 0;
    logic [31:0] fifo_seq = 32'd1;

    sfp_tx_framer #(
        .LINE_WORDS(LW),
        .VS_GUARD  (GUARD),
        .LINE_GAP  (GAP)
    ) dut (
        .tx_clk       (tx_clk),
        .tx_rst_n     (tx_rst_n),
        .vs_in        (vs_in),
        .line_req     (line_req),
        .payload_data (payload_data),
        .payload_empty(payload_empty),
        .payload_rd_en(payload_rd_en),
        .tx_data      (tx_data),
        .tx_charisk   (tx_charisk),
        .busy         (busy),
        .line_drop    (line_drop),
        .underrun     (underrun)
    );

    initial begin
        tx_clk = 1'b0;
        forever #5 tx_clk = ~tx_clk;
    end

    always @(posedge tx_clk) cyc <= cyc + 1;

    // Line FIFO model: dout follows a read by one cycle and holds while empty
    always @(posedge tx_clk) begin
        if (payload_rd_en && !payload_empty) begin
            payload_data <= fifo_seq;
            fifo_seq     <= fifo_seq + 32'd1;
        end
    end

    always @(negedge tx_clk) begin
        if (line_drop) drop_seen++;
        if (underrun) und_seen++;
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            total++;
            if (mon_e.cyc != cyc) begin
                bad++;
                $display("FAIL stale: expectation for cycle %0d reached at cycle %0d", mon_e.cyc, cyc);
            end else if (mon_e.kind == KIND_WORD) begin
                if (tx_data !== mon_e.data || tx_charisk !== mon_e.k ||
                    payload_rd_en !== mon_e.rd || busy !== mon_e.bz) begin
                    bad++;
                    $display("FAIL word@%0d: got data=%h k=%b rd=%b busy=%b, want data=%h k=%b rd=%b busy=%b",
                             cyc, tx_data, tx_charisk, payload_rd_en, busy,
                             mon_e.data, mon_e.k, mon_e.rd, mon_e.bz);
                end
            end else if (mon_e.kind == KIND_DROP) begin
                if (drop_seen != int'(mon_e.data)) begin
                    bad++;
                    $display("FAIL line_drop count@%0d: got %0d, want %0d", cyc, drop_seen, mon_e.data);
                end
            end else begin
                if (und_seen != int'(mon_e.data)) begin
                    bad++;
                    $display("FAIL underrun count@%0d: got %0d, want %0d", cyc, und_seen, mon_e.data);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge tx_clk);
        #1;
    endtask

    task automatic push_exp(input int c, input int kind, input logic [31:0] d,
                            input logic [3:0] k, input logic rd, input logic bz);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        e.data = d;
        e.k    = k;
        e.rd   = rd;
        e.bz   = bz;
        sb.push_back(e);
    endtask

    task automatic exp_idle(input int c, input int n, input logic bz);
        for (int i = 0; i < n; i++) push_exp(c + i, KIND_WORD, IDLE_W, 4'b0001, 1'b0, bz);
    endtask

    task automatic exp_vs(input int c);
        push_exp(c,     KIND_WORD, VS1_W, 4'b0001, 1'b0, 1'b1);
        push_exp(c + 1, KIND_WORD, VS2_W, 4'b0001, 1'b0, 1'b1);
        exp_idle(c + 2, GUARD, 1'b1);
    endtask

    task automatic exp_line(input int c, input logic [31:0] first, input bit held);
        push_exp(c,     KIND_WORD, ST1_W, 4'b0001, 1'b1, 1'b1);
        push_exp(c + 1, KIND_WORD, ST2_W, 4'b0001, 1'b1, 1'b1);
        for (int i = 0; i < LW; i++) begin
            push_exp(c + 2 + i, KIND_WORD, held ? first : first + 32'(i), 4'b0000,
                     (i < LW - 2) ? 1'b1 : 1'b0, 1'b1);
        end
        push_exp(c + 2 + LW, KIND_WORD, END1_W, 4'b0001, 1'b0, 1'b1);
        push_exp(c + 3 + LW, KIND_WORD, END2_W, 4'b0001, 1'b0, 1'b1);
        exp_idle(c + 4 + LW, GAP, 1'b1);
    endtask

    task automatic exp_counts(input int c, input int drops, input int unds);
        push_exp(c, KIND_DROP, 32'(drops), 4'b0000, 1'b0, 1'b0);
        push_exp(c, KIND_UND,  32'(unds),  4'b0000, 1'b0, 1'b0);
    endtask

    initial begin
        int c;
        tx_rst_n      = 1'b0;
        vs_in         = 1'b0;
        line_req      = 1'b0;
        payload_empty = 1'b0;
        payload_data  = 32'd0;

        // Reset values, then 50 quiet cycles
        tick(3);
        exp_idle(cyc, 1, 1'b0);
        tx_rst_n = 1'b1;
        exp_idle(cyc + 1, 50, 1'b0);
        tick(50);

        // Single line from idle: START1 two cycles after the request
        c = cyc;
        line_req = 1'b1;
        exp_line(c + 2, 32'd1, 1'b0);
        tick(1);
        line_req = 1'b0;
        tick(30);

        // Frame sync with a line request during the guard
        c = cyc;
        vs_in = 1'b1;
        exp_vs(c + 2);
        tick(1);
        vs_in = 1'b0;
        tick(9);
        line_req = 1'b1;
        exp_line(c + 4 + GUARD, 32'd5, 1'b0);
        tick(1);
        line_req = 1'b0;
        tick(150);

        // Collision, then a frame sync raised mid-payload waits for the gap
        c = cyc;
        vs_in    = 1'b1;
        line_req = 1'b1;
        exp_vs(c + 2);
        exp_line(c + 4 + GUARD, 32'd9, 1'b0);
        tick(1);
        vs_in    = 1'b0;
        line_req = 1'b0;
        tick(134);
        vs_in = 1'b1;
        exp_vs(c + 156);
        exp_idle(c + 158 + GUARD, 4, 1'b0);
        tick(1);
        vs_in = 1'b0;
        tick(160);
        exp_counts(cyc + 1, 0, 0);
        tick(2);

        // Second request while one is pending is dropped
        c = cyc;
        vs_in = 1'b1;
        exp_vs(c + 2);
        tick(1);
        vs_in = 1'b0;
        tick(9);
        line_req = 1'b1;
        tick(1);
        line_req = 1'b0;
        tick(9);
        line_req = 1'b1;
        exp_line(c + 4 + GUARD, 32'd13, 1'b0);
        exp_idle(c + 156, 20, 1'b0);
        tick(1);
        line_req = 1'b0;
        tick(165);
        exp_counts(cyc + 1, 1, 0);
        tick(2);

        // Underrun: framing unchanged, payload repeats the held FIFO word
        payload_empty = 1'b1;
        c = cyc;
        line_req = 1'b1;
        exp_line(c + 2, 32'd16, 1'b1);
        tick(1);
        line_req = 1'b0;
        tick(30);
        exp_counts(cyc + 1, 1, 4);
        tick(2);
        payload_empty = 1'b0;

        // Reset mid-line aborts without an END pair
        c = cyc;
        line_req = 1'b1;
        push_exp(c + 2, KIND_WORD, ST1_W, 4'b0001, 1'b1, 1'b1);
        push_exp(c + 3, KIND_WORD, ST2_W, 4'b0001, 1'b1, 1'b1);
        tick(1);
        line_req = 1'b0;
        tick(3);
        tx_rst_n = 1'b0;
        exp_idle(c + 4, 17, 1'b0);
        tick(4);
        tx_rst_n = 1'b1;
        tick(14);
        exp_counts(cyc + 1, 1, 4);
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
